// File: rtl/cu_vertex_line_unpacker.sv
// cu_vertex_line_unpacker
// Takes one returned read-response cacheline of packed little-endian vertex
// elements and streams them out one per cycle, byte-swapped, with the vertex
// id of each element and a marker on the final element of the line.
module cu_vertex_line_unpacker #(
    parameter int VERTEX_SIZE      = 4,
    parameter int VERTEX_SIZE_BITS = VERTEX_SIZE * 8,
    parameter int LINE_BYTES       = 128,
    parameter int LINE_BITS        = LINE_BYTES * 8,
    parameter int ELEMS_PER_LINE   = LINE_BYTES / VERTEX_SIZE
) (
    input  logic                        clock,
    input  logic                        rstn,
    input  logic                        enable,
    input  logic                        line_in_valid,
    output logic                        line_in_ready,
    input  logic [LINE_BITS-1:0]        line_in_data,
    input  logic [11:0]                 line_in_size,
    input  logic [VERTEX_SIZE_BITS-1:0] line_in_base_id,
    output logic                        vertex_out_valid,
    input  logic                        vertex_out_ready,
    output logic [VERTEX_SIZE_BITS-1:0] vertex_out_id,
    output logic [VERTEX_SIZE_BITS-1:0] vertex_out_data,
    output logic                        vertex_out_last,
    output logic                        size_error,
    output logic [31:0]                 lines_count,
    output logic [31:0]                 vertices_count
);

    // Element index/count are one bit wider than the element select so that a
    // full line (count == ELEMS_PER_LINE) is representable.
    localparam int ELEM_SEL_W = $clog2(ELEMS_PER_LINE);
    localparam int IDX_W      = ELEM_SEL_W + 1;
    localparam int SH_W       = $clog2(VERTEX_SIZE_BITS);
    localparam int OFF_W      = ELEM_SEL_W + SH_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT_START,
        S_SHIFT,
        S_SHIFT_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic                        w_accept;
    logic                        w_legal;
    logic                        w_last;
    logic                        w_hs;
    logic [LINE_BITS-1:0]        r_data;
    logic [VERTEX_SIZE_BITS-1:0] r_base;
    logic [IDX_W-1:0]            r_count;
    logic [IDX_W-1:0]            r_idx;
    logic [OFF_W-1:0]            w_off;
    logic [VERTEX_SIZE_BITS-1:0] w_elem;

    // Legal request sizes are powers of two between one element and one line.
    function automatic logic f_size_legal(input logic [11:0] size);
        return (size >= 12'(VERTEX_SIZE)) && (size <= 12'(LINE_BYTES)) &&
               ((size & (size - 12'd1)) == 12'd0);
    endfunction

    // Memory holds each element little-endian; reverse the byte order.
    function automatic logic [VERTEX_SIZE_BITS-1:0] f_byte_swap(
        input logic [VERTEX_SIZE_BITS-1:0] elem
    );
        logic [VERTEX_SIZE_BITS-1:0] swapped;
        swapped = '0;
        for (int i = 0; i < VERTEX_SIZE; i++) begin
            swapped[i*8 +: 8] = elem[(VERTEX_SIZE-1-i)*8 +: 8];
        end
        return swapped;
    endfunction

    assign w_legal = f_size_legal(line_in_size);
    assign w_last  = (r_idx == r_count - IDX_W'(1));
    assign w_off   = {r_idx[ELEM_SEL_W-1:0], {SH_W{1'b0}}};
    assign w_elem  = r_data[w_off +: VERTEX_SIZE_BITS];

    // Output stream is driven from registered state and index; quiet when idle.
    assign vertex_out_valid = (r_state == S_SHIFT);
    assign vertex_out_last  = vertex_out_valid && w_last;
    assign vertex_out_id    = vertex_out_valid ? (r_base + VERTEX_SIZE_BITS'(r_idx)) : '0;
    assign vertex_out_data  = vertex_out_valid ? f_byte_swap(w_elem) : '0;
    assign w_hs             = vertex_out_valid && vertex_out_ready;

    // State register; reset mid-line abandons the line at once.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and line-accept handshake; enable only gates new lines.
    always_comb begin
        w_next        = r_state;
        line_in_ready = 1'b0;
        w_accept      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                line_in_ready = enable;
                w_accept      = enable && line_in_valid;
                if (w_accept && w_legal) begin
                    w_next = S_SHIFT_START;
                end
            end
            S_SHIFT_START: w_next = S_SHIFT;
            S_SHIFT: begin
                if (w_hs && w_last) begin
                    w_next = S_SHIFT_DONE;
                end
            end
            S_SHIFT_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Line buffer, element index, statistics counters and sticky size error.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_data         <= '0;
            r_base         <= '0;
            r_count        <= '0;
            r_idx          <= '0;
            size_error     <= 1'b0;
            lines_count    <= '0;
            vertices_count <= '0;
        end else begin
            if (w_accept) begin
                r_data  <= line_in_data;
                r_base  <= line_in_base_id;
                r_count <= IDX_W'(line_in_size >> $clog2(VERTEX_SIZE));
                if (w_legal) begin
                    lines_count <= lines_count + 32'd1;
                end else if (line_in_size != 12'd0) begin
                    size_error <= 1'b1;
                end
            end
            if (r_state == S_SHIFT_START) begin
                r_idx <= '0;
            end else if (w_hs) begin
                r_idx          <= r_idx + IDX_W'(1);
                vertices_count <= vertices_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_cu_vertex_line_unpacker.sv
// Directed and randomized bench for cu_vertex_line_unpacker with a queue-based
// reference model of the expected vertex stream.
module tb_cu_vertex_line_unpacker;

    logic          clock = 1'b0;
    logic          rstn = 1'b0;
    logic          enable = 1'b0;
    logic          line_in_valid = 1'b0;
    logic          line_in_ready;
    logic [1023:0] line_in_data = '0;
    logic [11:0]   line_in_size = '0;
    logic [31:0]   line_in_base_id = '0;
    logic          vertex_out_valid;
    logic          vertex_out_ready = 1'b0;
    logic [31:0]   vertex_out_id;
    logic [31:0]   vertex_out_data;
    logic          vertex_out_last;
    logic          size_error;
    logic [31:0]   lines_count;
    logic [31:0]   vertices_count;

    cu_vertex_line_unpacker dut (
        .clock            (clock),
        .rstn             (rstn),
        .enable           (enable),
        .line_in_valid    (line_in_valid),
        .line_in_ready    (line_in_ready),
        .line_in_data     (line_in_data),
        .line_in_size     (line_in_size),
        .line_in_base_id  (line_in_base_id),
        .vertex_out_valid (vertex_out_valid),
        .vertex_out_ready (vertex_out_ready),
        .vertex_out_id    (vertex_out_id),
        .vertex_out_data  (vertex_out_data),
        .vertex_out_last  (vertex_out_last),
        .size_error       (size_error),
        .lines_count      (lines_count),
        .vertices_count   (vertices_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] id;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   m_lines = 0;
    int   m_verts = 0;
    logic m_err   = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reverse byte order of a 32-bit word using shifts and masks.
    function automatic logic [31:0] ref_swap(input logic [31:0] v);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 4; i++) begin
            r = r | (((v >> (8 * i)) & 32'hFF) << (8 * (3 - i)));
        end
        return r;
    endfunction

    // Reference model: what a line of a given size should produce.
    task automatic model_line(input logic [11:0] sz, input logic [31:0] base, input logic [1023:0] data);
        int   n;
        bit   legal;
        exp_t e;
        legal = (sz >= 4) && (sz <= 128) && ((sz & (sz - 1)) == 0);
        if (legal) begin
            n = int'(sz) / 4;
            for (int k = 0; k < n; k++) begin
                e.id   = base + 32'(k);
                e.data = ref_swap(32'(data >> (32 * k)));
                e.last = (k == n - 1);
                exp_q.push_back(e);
            end
            m_lines++;
        end else if (sz != 0) begin
            m_err = 1'b1;
        end
    endtask

    task automatic send_line(input logic [11:0] sz, input logic [31:0] base, input logic [1023:0] data,
                             output int acc_cyc, output int tries);
        line_in_size    = sz;
        line_in_base_id = base;
        line_in_data    = data;
        line_in_valid   = 1'b1;
        acc_cyc = -1;
        tries   = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            tries++;
            if (line_in_ready === 1'b1) begin
                acc_cyc = cyc;
                @(negedge clock);
                break;
            end
            @(negedge clock);
        end
        line_in_valid = 1'b0;
        check("line_accepted", acc_cyc >= 0, 1'b1);
        if (acc_cyc >= 0) model_line(sz, base, data);
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: random.
    task automatic drain(input int mode, input int max_hs, input int budget,
                         output int hs, output int first_v, output int last_h,
                         output logic [31:0] last_id, output logic rdy1, output logic rdy2);
        int tog;
        tog = 0; hs = 0; first_v = -1; last_h = -1; last_id = 32'hDEAD_BEEF;
        rdy1 = 1'b1; rdy2 = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (mode)
                0:       vertex_out_ready = 1'b1;
                1:       vertex_out_ready = (tog % 3 == 0);
                default: vertex_out_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (last_h >= 0 && cyc == last_h + 1) rdy1 = line_in_ready;
            if (last_h >= 0 && cyc == last_h + 2) rdy2 = line_in_ready;
            if (vertex_out_valid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                tog++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", vertex_out_valid, 1'b0);
                end else begin
                    check("out_id", vertex_out_id, exp_q[0].id);
                    check("out_data", vertex_out_data, exp_q[0].data);
                    check("out_last", vertex_out_last, exp_q[0].last);
                    if (vertex_out_ready) begin
                        if (vertex_out_last) last_id = vertex_out_id;
                        void'(exp_q.pop_front());
                        hs++;
                        m_verts++;
                        last_h = cyc;
                    end
                end
            end
            @(negedge clock);
            if (max_hs > 0 && hs == max_hs) break;
            if (exp_q.size() == 0 && last_h >= 0 && cyc >= last_h + 3) break;
        end
        vertex_out_ready = 1'b0;
        if (max_hs == 0) check("drain_complete", exp_q.size(), 0);
    endtask

    initial begin
        logic [1023:0] d;
        logic [31:0]   base;
        logic [31:0]   lid;
        logic          r1, r2;
        logic [11:0]   sz;
        int acc, tries, hs, fv, lh;

        // Reset state
        #3;
        check("rst_valid", vertex_out_valid, 1'b0);
        check("rst_id", vertex_out_id, 32'd0);
        check("rst_data", vertex_out_data, 32'd0);
        check("rst_last", vertex_out_last, 1'b0);
        check("rst_size_error", size_error, 1'b0);
        check("rst_lines", lines_count, 32'd0);
        check("rst_verts", vertices_count, 32'd0);
        @(negedge clock);
        rstn = 1'b1;
        enable = 1'b1;
        @(negedge clock);

        // Full 128-byte line, element k = bytes {k,02,03,04}
        for (int k = 0; k < 32; k++) d[k*32 +: 32] = {8'(k), 8'h02, 8'h03, 8'h04};
        send_line(12'd128, 32'd100, d, acc, tries);
        check("t1_first_data", exp_q[0].data, 32'h04030200);
        drain(0, 0, 200, hs, fv, lh, lid, r1, r2);
        check("t1_handshakes", hs, 32);
        check("t1_latency", fv, acc + 2);
        check("t1_last_id", lid, 32'd131);
        check("t1_lines", lines_count, 32'd1);
        check("t1_verts", vertices_count, 32'd32);

        // Id wrap and ready return timing
        for (int w = 0; w < 32; w++) d[w*32 +: 32] = $urandom;
        send_line(12'd8, 32'hFFFF_FFFF, d, acc, tries);
        drain(0, 0, 50, hs, fv, lh, lid, r1, r2);
        check("t2_handshakes", hs, 2);
        check("t2_last_id", lid, 32'h0000_0000);
        check("t2_ready_h1", r1, 1'b0);
        check("t2_ready_h2", r2, 1'b1);

        // Backpressure stalls
        for (int w = 0; w < 32; w++) d[w*32 +: 32] = $urandom;
        base = $urandom;
        send_line(12'd16, base, d, acc, tries);
        drain(1, 0, 80, hs, fv, lh, lid, r1, r2);
        check("t3_handshakes", hs, 4);
        check("t3_last_id", lid, base + 32'd3);
        check("t3_verts", vertices_count, 32'(m_verts));

        // Dropped sizes
        send_line(12'd0, 32'd5, d, acc, tries);
        check("t4_size0_tries", tries, 1);
        check("t4_size0_err", size_error, 1'b0);
        drain(0, 0, 5, hs, fv, lh, lid, r1, r2);
        check("t4_size0_quiet", fv < 0, 1'b1);
        send_line(12'd12, 32'd5, d, acc, tries);
        check("t4_size12_tries", tries, 1);
        check("t4_size12_err", size_error, 1'b1);
        send_line(12'd2, 32'd5, d, acc, tries);
        check("t4_size2_tries", tries, 1);
        drain(0, 0, 5, hs, fv, lh, lid, r1, r2);
        check("t4_quiet", fv < 0, 1'b1);
        check("t4_err_sticky", size_error, 1'b1);
        check("t4_lines", lines_count, 32'(m_lines));

        // Enable gating
        enable = 1'b0;
        line_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t5_ready_low", line_in_ready, 1'b0);
            @(negedge clock);
        end
        line_in_valid = 1'b0;
        enable = 1'b1;
        for (int w = 0; w < 32; w++) d[w*32 +: 32] = $urandom;
        base = $urandom;
        send_line(12'd32, base, d, acc, tries);
        enable = 1'b0;
        drain(0, 0, 60, hs, fv, lh, lid, r1, r2);
        check("t5_handshakes", hs, 8);
        enable = 1'b1;

        // Reset in mid-line
        for (int w = 0; w < 32; w++) d[w*32 +: 32] = $urandom;
        send_line(12'd128, 32'd7, d, acc, tries);
        drain(0, 5, 60, hs, fv, lh, lid, r1, r2);
        check("t6_pre_hs", hs, 5);
        check("t6_elem5_valid", vertex_out_valid, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_valid", vertex_out_valid, 1'b0);
        check("t6_rst_id", vertex_out_id, 32'd0);
        check("t6_rst_data", vertex_out_data, 32'd0);
        check("t6_rst_last", vertex_out_last, 1'b0);
        check("t6_rst_err", size_error, 1'b0);
        check("t6_rst_lines", lines_count, 32'd0);
        check("t6_rst_verts", vertices_count, 32'd0);
        exp_q.delete();
        m_lines = 0; m_verts = 0; m_err = 1'b0;
        @(negedge clock);
        rstn = 1'b1;
        drain(0, 0, 8, hs, fv, lh, lid, r1, r2);
        check("t6_quiet_after", fv < 0, 1'b1);
        base = $urandom;
        send_line(12'd4, base, d, acc, tries);
        drain(0, 0, 30, hs, fv, lh, lid, r1, r2);
        check("t6_single", hs, 1);
        check("t6_single_id", lid, base);

        // Random legal lines with random backpressure
        for (int n = 0; n < 6; n++) begin
            for (int w = 0; w < 32; w++) d[w*32 +: 32] = $urandom;
            sz = 12'd4 << $urandom_range(0, 5);
            base = $urandom;
            send_line(sz, base, d, acc, tries);
            drain(2, 0, 400, hs, fv, lh, lid, r1, r2);
            check("rnd_handshakes", hs, int'(sz) / 4);
            check("rnd_latency", fv, acc + 2);
        end
        check("end_lines", lines_count, 32'(m_lines));
        check("end_verts", vertices_count, 32'(m_verts));
        check("end_err", size_error, m_err);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cu_vertex_line_unpacker.md
Name: cu_vertex_line_unpacker

Overview:
- Receive-side counterpart of the vertex read-request generator in the PageRank CSR PULL compute unit.
- Accepts one returned read-response cacheline: up to 128 bytes, with the byte size the requester issued (power of 2) and the vertex id of the line's first element.
- Byte-swaps each vertex-sized element from little-endian memory order.
- Serialises the elements one per cycle onto a valid/ready vertex-data stream feeding the vertex/edge pipeline.

Parameters:
- VERTEX_SIZE, 4, bytes per vertex element.
- VERTEX_SIZE_BITS, 32, VERTEX_SIZE*8.
- LINE_BYTES, 128, cacheline bytes.
- LINE_BITS, 1024, LINE_BYTES*8.
- ELEMS_PER_LINE, 32, LINE_BYTES/VERTEX_SIZE.

Ports:
- clock  in  1  single clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, no new line is accepted; a line in flight completes.
- line_in_valid  in  1  response line present.
- line_in_ready  out  1  line accepted on valid&&ready.
- line_in_data  in  [0:LINE_BITS-1]  element k at bits [k*32 +: 32], little-endian bytes.
- line_in_size  in  [0:11]  request size in bytes.
- line_in_base_id  in  [0:VERTEX_SIZE_BITS-1]  vertex id of element 0.
- vertex_out_valid  out  1  element present.
- vertex_out_ready  in  1  consumer accepts.
- vertex_out_id  out  [0:VERTEX_SIZE_BITS-1]  base_id + k, modulo 2^32.
- vertex_out_data  out  [0:VERTEX_SIZE_BITS-1]  byte-reversed element k.
- vertex_out_last  out  1  marks the final element of a line.
- size_error  out  1  sticky; set when an illegal size is received.
- lines_count  out  32  accepted legal lines, wraps.
- vertices_count  out  32  elements handed off, wraps.

Behaviour:
- Reset (async, rstn=0): state=IDLE; every output 0, including the line buffer, counters and size_error. Assertion mid-shift discards the line immediately. No output after rstn rises until a new line is accepted.
- States: IDLE, SHIFT_START, SHIFT, SHIFT_DONE.
- IDLE:
  - line_in_ready = enable.
  - On accept, latch data, base_id and count = line_in_size>>2.
  - Legal sizes are 4, 8, 16, 32, 64 and 128:
    - Legal size: lines_count+1, next state SHIFT_START.
  - Size 0: line dropped, stay IDLE; no error, no count change.
  - Any other size (1, 2, non-power-of-2, >128): line dropped, size_error<=1, stay IDLE.
- SHIFT_START (1 cycle): idx<=0; present element 0. vertex_out_valid is asserted the cycle after this state. First-element latency from accept is 2 cycles (accept at N, vertex_out_valid at N+2).
- SHIFT:
  - vertex_out_valid=1; outputs are driven from registered idx.
  - Outputs hold stable while vertex_out_ready=0.
  - On valid&&ready: vertices_count+1, idx+1.
  - If idx==count-1 (vertex_out_last=1) → SHIFT_DONE, with valid low the next cycle.
- SHIFT_DONE (1 cycle): clear valid and last → IDLE.
- line_in_ready is 0 in every state except IDLE.
- Byte swap: out byte i = in byte (VERTEX_SIZE-1-i) within each element.
- Arithmetic widths:
  - idx: 6 bits.
  - count: 6 bits, max 32.
  - id addition is 32-bit wrapping (base 0xFFFFFFFF, k=1 → 0x00000000).
- Elements beyond count in the line are ignored.
- Dropping enable during SHIFT has no effect on that line.
- Counters wrap 0xFFFFFFFF→0. size_error clears only on reset.

Test Plan:
- 128-byte line, base_id 100, element k = {k, 0x02, 0x03, 0x04} bytes, ready held 1 → 32 consecutive outputs. Ids 100..131, data 0x040302kk, last only on id 131. Accepted at cycle N, first valid at N+2. lines_count=1, vertices_count=32.
- Size 8, base_id 0xFFFFFFFF → two outputs with ids 0xFFFFFFFF then 0x00000000, last on the second. line_in_ready returns 1 two cycles after the final handshake.
- Size 16 with vertex_out_ready toggling 1,0,0,1,… → exactly 4 handshakes. Data and id are unchanged during stalls. No element is duplicated or skipped.
- Size 0, then size 12, then size 2 → no vertex_out_valid. size_error=1 after the size-12 line and remains 1. lines_count=0. Each line is accepted in a single cycle.
- enable=0 with line_in_valid=1 → line_in_ready=0 indefinitely. Dropping enable mid-line of size 32 still emits all 8 elements.
- rstn pulsed low during element 5 of a 128-byte line → all outputs 0 immediately; no further elements after release. The next line (size 4) emits exactly one element.
